// File: rtl/fpgav2_prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpgav2_prog_pkg
//  Description : Shared constants, state encoding and CRC-16 step function
//                for the fpgav2 configuration chain loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpgav2_prog_pkg;

    localparam int          NUM_BITS_DEFAULT = 1480;
    localparam logic [15:0] CRC_POLY         = 16'h1021;
    localparam logic [15:0] CRC_INIT         = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // One bit-serial CRC-16 step, MSB-first feedback
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpgav2_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpgav2_prog_ctrl_if
//  Description : Byte stream handshake plus fpgav2 programming chain pins.
//                master = loader side, slave = byte source / fabric side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpgav2_prog_ctrl_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       prog_in;
    logic       prog_clk;
    logic       prog_en;
    logic       prog_out;

    modport master (
        input  cfg_data, cfg_valid, prog_out,
        output cfg_ready, prog_in, prog_clk, prog_en
    );

    modport slave (
        output cfg_data, cfg_valid, prog_out,
        input  cfg_ready, prog_in, prog_clk, prog_en
    );
endinterface
`default_nettype wire

// File: rtl/fpgav2_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : fpgav2_crc16
//  Description : Bit-serial CRC-16 accumulator (poly/init from package).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpgav2_crc16
    import fpgav2_prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // Accumulate one bit per enabled cycle; clear restarts from the seed
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpgav2_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fpgav2_prog_ctrl
//  Description : Streams NUM_BITS configuration bits into the fpgav2 chain
//                (bit 0 first) with a 3-phase prog_clk, CRCs the shifted
//                data and the readback, and reports whether the readback
//                matches the previous load.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpgav2_prog_ctrl
    import fpgav2_prog_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT,
    parameter int DIV      = 1
) (
    input  logic               clk,
    input  logic               rst,
    fpgav2_prog_ctrl_if.master pif,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               verify_valid,
    output logic               verify_ok
);

    localparam int               BIT_W      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int               DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NUM_BITS - 1);
    localparam logic [DIV_W-1:0] LAST_PHASE = DIV_W'(DIV - 1);

    state_t           r_state;
    logic [7:0]       r_byte;
    logic [BIT_W-1:0] r_bit_idx;
    logic [2:0]       r_bit_in_byte;
    logic [DIV_W-1:0] r_phase;
    logic             r_have_ref;
    logic [15:0]      r_ref_crc;

    logic             w_accept;
    logic             w_sample;
    logic             w_bit_val;
    logic             w_phase_last;
    logic [15:0]      w_shift_crc;
    logic [15:0]      w_rdbk_crc;

    assign w_accept     = (r_state == ST_IDLE) && start && !busy;
    // First SETUP cycle of a bit: prog_out still shows the old chain bit
    assign w_sample     = (r_state == ST_SETUP) && (r_phase == '0);
    assign w_bit_val    = r_byte[r_bit_in_byte];
    assign w_phase_last = (r_phase == LAST_PHASE);

    fpgav2_crc16 u_crc_shift (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .en    (w_sample),
        .din   (w_bit_val),
        .crc   (w_shift_crc)
    );

    fpgav2_crc16 u_crc_rdbk (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .en    (w_sample),
        .din   (pif.prog_out),
        .crc   (w_rdbk_crc)
    );

    // Load sequencer: byte fetch, per-bit SETUP/HIGH/LOW phases, finish
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_byte        <= '0;
            r_bit_idx     <= '0;
            r_bit_in_byte <= '0;
            r_phase       <= '0;
            r_have_ref    <= 1'b0;
            r_ref_crc     <= CRC_INIT;
            pif.prog_en   <= 1'b0;
            pif.prog_clk  <= 1'b0;
            pif.prog_in   <= 1'b0;
            pif.cfg_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            verify_valid  <= 1'b0;
            verify_ok     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state       <= ST_FETCH;
                        r_bit_idx     <= '0;
                        r_bit_in_byte <= '0;
                        r_phase       <= '0;
                        pif.prog_en   <= 1'b1;
                        pif.cfg_ready <= 1'b1;
                        busy          <= 1'b1;
                        verify_valid  <= 1'b0;
                        verify_ok     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // prog_clk stays low and prog_in holds while stalled
                    if (pif.cfg_valid && pif.cfg_ready) begin
                        r_byte        <= pif.cfg_data;
                        r_state       <= ST_SETUP;
                        r_phase       <= '0;
                        pif.cfg_ready <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (r_phase == '0) begin
                        pif.prog_in <= w_bit_val;
                    end
                    if (w_phase_last) begin
                        r_phase      <= '0;
                        r_state      <= ST_HIGH;
                        pif.prog_clk <= 1'b1;
                    end else begin
                        r_phase <= r_phase + DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_phase_last) begin
                        r_phase      <= '0;
                        r_state      <= ST_LOW;
                        pif.prog_clk <= 1'b0;
                    end else begin
                        r_phase <= r_phase + DIV_W'(1);
                    end
                end
                ST_LOW: begin
                    if (!w_phase_last) begin
                        r_phase <= r_phase + DIV_W'(1);
                    end else begin
                        r_phase <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            // Both CRCs are complete here; compare against the
                            // previous reference before replacing it
                            r_state      <= ST_FINISH;
                            pif.prog_en  <= 1'b0;
                            done         <= 1'b1;
                            r_ref_crc    <= w_shift_crc;
                            r_have_ref   <= 1'b1;
                            verify_valid <= r_have_ref;
                            verify_ok    <= (w_rdbk_crc == r_ref_crc);
                        end else begin
                            r_bit_idx     <= r_bit_idx + BIT_W'(1);
                            r_bit_in_byte <= r_bit_in_byte + 3'd1;
                            if (r_bit_in_byte == 3'd7) begin
                                r_state       <= ST_FETCH;
                                pif.cfg_ready <= 1'b1;
                            end else begin
                                r_state <= ST_SETUP;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpgav2_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpgav2_prog_ctrl
//  Description : Directed bench: 1480-bit DIV=1 loader against a shift-chain
//                fabric model, plus a 20-bit DIV=3 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpgav2_prog_ctrl;

    localparam int NB       = 1480;
    localparam int NBYTES   = 185;
    localparam int FLIP_IDX = 700;
    localparam int BUDGET   = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done, vv, vo;
    logic start3, busy3, done3, vv3, vo3;

    fpgav2_prog_ctrl_if pif ();
    fpgav2_prog_ctrl_if pif3 ();

    fpgav2_prog_ctrl #(.NUM_BITS(NB), .DIV(1)) dut (
        .clk(clk), .rst(rst), .pif(pif.master), .start(start), .busy(busy),
        .done(done), .verify_valid(vv), .verify_ok(vo)
    );

    fpgav2_prog_ctrl #(.NUM_BITS(20), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .pif(pif3.master), .start(start3), .busy(busy3),
        .done(done3), .verify_valid(vv3), .verify_ok(vo3)
    );

    int checks = 0;
    int failures = 0;

    // fabric model for the 1480-bit chain
    logic [NB-1:0] chain;
    int            rise_cnt;
    logic          last_pclk;
    logic          flip_en;
    assign pif.prog_out  = chain[NB-1] ^ (flip_en && (rise_cnt == FLIP_IDX));
    assign pif3.prog_out = 1'b0;

    // byte source state
    int   cyc, byte_idx, xfers, pat_sel, stall_after, stall_left, stall_seen, stall_bad, stall_rise;
    logic stall_pin;

    // DIV=3 instance monitors
    int          b3, rise3, hi_run, hi_runs, bad_hi, done3_cnt;
    logic        last3;
    logic [19:0] shifted3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int sel, input int k);
        logic [7:0] kk;
        kk = k[7:0];
        case (sel)
            0:       return kk ^ 8'h5A;
            1:       return kk * 8'd7 + 8'd3;
            default: return ~(kk * 8'd13);
        endcase
    endfunction

    function automatic logic [7:0] tbl3(input int k);
        case (k)
            0:       return 8'hC3;
            1:       return 8'h5A;
            2:       return 8'h96;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int chain_errs(input int sel);
        int e;
        logic [7:0] b;
        e = 0;
        for (int k = 0; k < NB; k++) begin
            b = pat(sel, k / 8);
            if (chain[NB-1-k] !== b[k%8]) e++;
        end
        return e;
    endfunction

    // Advance one clock; update fabric models, byte sources and monitors
    task automatic step();
        logic xfer, xfer3;
        xfer  = pif.cfg_valid && pif.cfg_ready;
        xfer3 = pif3.cfg_valid && pif3.cfg_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (pif.prog_clk && !last_pclk) begin
            chain = {chain[NB-2:0], pif.prog_in};
            rise_cnt++;
        end
        last_pclk = pif.prog_clk;
        if (xfer) begin
            byte_idx++;
            xfers++;
        end
        if (byte_idx >= NBYTES) begin
            pif.cfg_valid = 1'b0;
        end else if (stall_after >= 0 && byte_idx == stall_after + 1 && stall_left > 0) begin
            pif.cfg_valid = 1'b0;
            if (pif.cfg_ready) begin
                if (stall_seen == 0) begin
                    stall_pin  = pif.prog_in;
                    stall_rise = rise_cnt;
                end
                if (pif.prog_en !== 1'b1 || pif.prog_clk !== 1'b0 ||
                    pif.prog_in !== stall_pin || rise_cnt != stall_rise) stall_bad++;
                stall_seen++;
                stall_left--;
            end
        end else begin
            pif.cfg_valid = 1'b1;
        end
        pif.cfg_data = pat(pat_sel, byte_idx);

        if (xfer3) b3++;
        pif3.cfg_data = tbl3(b3);
        if (pif3.prog_clk && !last3) begin
            if (rise3 < 20) shifted3[rise3] = pif3.prog_in;
            rise3++;
        end
        if (pif3.prog_clk) begin
            hi_run++;
        end else if (last3) begin
            if (hi_run != 3) bad_hi++;
            hi_runs++;
            hi_run = 0;
        end
        last3 = pif3.prog_clk;
        if (done3) done3_cnt++;
    endtask

    // One full load; abort_at >= 0 asserts rst once that many bits are in
    task automatic run_load(input int sel, input int stall_at, input logic flip,
                            input int abort_at, output int done_cyc);
        byte_idx    = 0;
        xfers       = 0;
        pat_sel     = sel;
        stall_after = stall_at;
        stall_left  = 10;
        stall_seen  = 0;
        stall_bad   = 0;
        flip_en     = flip;
        rise_cnt    = 0;
        done_cyc    = -1;
        pif.cfg_data = pat(sel, 0);
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_prog_en", pif.prog_en, 1'b1);
        check("accept_cfg_ready", pif.cfg_ready, 1'b1);
        check("accept_vv_cleared", vv, 1'b0);
        while (!done && cyc < BUDGET) begin
            if (abort_at >= 0 && rise_cnt == abort_at) begin
                rst = 1'b1;
                step();
                check("abort_prog_en", pif.prog_en, 1'b0);
                check("abort_prog_clk", pif.prog_clk, 1'b0);
                check("abort_busy", busy, 1'b0);
                rst = 1'b0;
                step();
                return;
            end
            step();
        end
        check("load_done_seen", done, 1'b1);
        done_cyc = cyc;
        step();
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_prog_en", pif.prog_en, 1'b0);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        pif.cfg_valid = 1'b0; pif.cfg_data = 8'h00;
        pif3.cfg_valid = 1'b1; pif3.cfg_data = tbl3(0);
        chain = '0; rise_cnt = 0; last_pclk = 1'b0; flip_en = 1'b0;
        cyc = 0; byte_idx = NBYTES; xfers = 0; pat_sel = 0;
        stall_after = -1; stall_left = 0; stall_seen = 0; stall_bad = 0;
        stall_rise = 0; stall_pin = 1'b0;
        b3 = 0; rise3 = 0; hi_run = 0; hi_runs = 0; bad_hi = 0; done3_cnt = 0;
        last3 = 1'b0; shifted3 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_prog_en", pif.prog_en, 1'b0);
        check("rst_prog_clk", pif.prog_clk, 1'b0);
        check("rst_prog_in", pif.prog_in, 1'b0);
        check("rst_cfg_ready", pif.cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vv", vv, 1'b0);
        check("rst_vo", vo, 1'b0);

        // reset load: timing, edge count, no reference yet
        run_load(0, -1, 1'b0, -1, dc);
        check("l1_done_cycle", dc, 185 + 1480 * 3 + 1);
        check("l1_rises", rise_cnt, NB);
        check("l1_bytes", xfers, NBYTES);
        check("l1_vv", vv, 1'b0);
        check("l1_chain", chain_errs(0), 0);

        // pattern A then pattern B
        run_load(1, -1, 1'b0, -1, dc);
        check("la_vv", vv, 1'b1);
        check("la_vo", vo, 1'b1);
        run_load(2, -1, 1'b0, -1, dc);
        check("lb_vv", vv, 1'b1);
        check("lb_vo", vo, 1'b1);
        check("lb_chain", chain_errs(2), 0);

        // corrupted readback of bit 700
        run_load(2, -1, 1'b1, -1, dc);
        check("flip_vv", vv, 1'b1);
        check("flip_vo", vo, 1'b0);

        // 10-cycle source stall before byte 51
        run_load(1, 50, 1'b0, -1, dc);
        check("stall_cycles", stall_seen, 10);
        check("stall_violations", stall_bad, 0);
        check("stall_done_cycle", dc, 185 + 1480 * 3 + 1 + 10);
        check("stall_rises", rise_cnt, NB);
        check("stall_chain", chain_errs(1), 0);
        check("stall_vv", vv, 1'b1);
        check("stall_vo", vo, 1'b1);

        // abort at bit 700, then a full load has no valid reference
        run_load(2, -1, 1'b0, FLIP_IDX, dc);
        run_load(1, -1, 1'b0, -1, dc);
        check("post_abort_vv", vv, 1'b0);
        check("post_abort_rises", rise_cnt, NB);
        check("post_abort_chain", chain_errs(1), 0);

        // DIV=3, 20-bit chain, second start while busy
        cyc = 0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        dc = -1;
        while (cyc < 2000 && dc < 0) begin
            start3 = (cyc == 50);
            step();
            if (done3 && dc < 0) dc = cyc;
        end
        start3 = 1'b0;
        repeat (300) step();
        check("d3_done_cycle", dc, 3 + 20 * 9 + 1);
        check("d3_done_count", done3_cnt, 1);
        check("d3_rises", rise3, 20);
        check("d3_high_runs", hi_runs, 20);
        check("d3_bad_high_len", bad_hi, 0);
        check("d3_bits", shifted3, 20'h65AC3);
        check("d3_busy_end", busy3, 1'b0);
        check("d3_vv", vv3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
